// File: rtl/rom_seq.sv
// rom_seq: serial instruction ROM sequencer.
// Tracks the 56-bit-time word using the sync strobe, assembles the serial
// ROM address, fetches one 10-bit word from the external array, and shifts
// it out on the shared instruction line when this chip is the selected ROM.
// It also watches the shared line for ROM-select instructions.
//
// Handshake: there is no ready path. is_oe is the valid qualifier for is.
// While is_oe is high, is carries one instruction bit per cycle, LSB first,
// during T45-T54. While is_oe is low, is is held at 0.
module rom_seq (
   input  logic       cph2,
   input  logic       nrst,
   input  logic       sync,
   input  logic       ia,
   input  logic       is_bus,
   input  logic [2:0] rom_id,
   input  logic [9:0] rom_data,
   output logic [7:0] rom_addr,
   output logic       is,
   output logic       is_oe,
   output logic       active,
   output logic       locked,
   output logic       state_dbg
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   localparam logic [5:0] T_ADDR_FIRST = 6'd20;
   localparam logic [5:0] T_ADDR_LAST  = 6'd27;
   localparam logic [5:0] T_ADDR_LOAD  = 6'd28;
   localparam logic [5:0] T_FETCH      = 6'd44;
   localparam logic [5:0] T_OUT_FIRST  = 6'd45;
   localparam logic [5:0] T_OUT_LAST   = 6'd54;
   localparam logic [5:0] T_LAST       = 6'd55;
   localparam logic [5:0] T_AFTER_SYNC = 6'd46;
   localparam logic [3:0] SYNC_MAX_RUN = 4'd10;
   localparam logic [6:0] SELECT_OP    = 7'b0010000;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       sync_q;
   logic [3:0] run_q;
   logic       blank_q, blank_d;
   logic       resync_err;
   logic       sync_rise, sync_long;
   logic [7:0] addr_sr;
   logic [9:0] latch_q;
   logic [9:0] obs_q;
   logic       in_win;
   logic [5:0] bit_off;
   logic [9:0] latch_sh;

   assign sync_rise = sync & ~sync_q;
   // The current high cycle is the 11th or later in a row.
   assign sync_long = sync & (run_q >= SYNC_MAX_RUN);

   // Next-state, word counter and blanking logic for the lock FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      blank_d    = blank_q;
      resync_err = 1'b0;
      case (state_q)
         UNLOCKED: begin
            cnt_d   = 6'd0;
            blank_d = 1'b0;
            if (sync_rise) begin
               state_d = LOCKED;
               cnt_d   = T_AFTER_SYNC;
            end
         end
         LOCKED: begin
            cnt_d = (cnt_q == T_LAST) ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == T_LAST) blank_d = 1'b0;
            if (sync_long) begin
               state_d = UNLOCKED;
               cnt_d   = 6'd0;
               blank_d = 1'b0;
            end else if (sync_rise) begin
               cnt_d = T_AFTER_SYNC;
               if (cnt_q != T_OUT_FIRST) begin
                  // A misplaced sync means this word's data is not trustworthy,
                  // so the output stays quiet until the word ends.
                  resync_err = 1'b1;
                  blank_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = UNLOCKED;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // Lock FSM state, word counter, sync history and blanking flag.
   always_ff @(posedge cph2 or negedge nrst) begin
      if (!nrst) begin
         state_q <= UNLOCKED;
         cnt_q   <= 6'd0;
         sync_q  <= 1'b0;
         run_q   <= 4'd0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync;
         blank_q <= blank_d;
         if (!sync)               run_q <= 4'd0;
         else if (run_q != 4'hF)  run_q <= run_q + 4'd1;
      end
   end

   // Address assembly, array address register, fetch latch and bus observer.
   always_ff @(posedge cph2 or negedge nrst) begin
      if (!nrst) begin
         addr_sr  <= 8'd0;
         rom_addr <= 8'd0;
         latch_q  <= 10'd0;
         obs_q    <= 10'd0;
      end else if (state_q == LOCKED) begin
         if (cnt_q >= T_ADDR_FIRST && cnt_q <= T_ADDR_LAST)
            addr_sr <= {ia, addr_sr[7:1]};
         if (cnt_q == T_ADDR_LOAD)
            rom_addr <= addr_sr;
         if (cnt_q == T_FETCH)
            latch_q <= rom_data;
         if (cnt_q >= T_OUT_FIRST && cnt_q <= T_OUT_LAST)
            obs_q <= {is_bus, obs_q[9:1]};
      end
   end

   // Selection flag. rom_id is static, so it also provides the reset value.
   // After reset, ROM 0 is the selected chip.
   always_ff @(posedge cph2 or negedge nrst) begin
      if (!nrst) begin
         active <= (rom_id == 3'd0);
      end else if (state_q == LOCKED && cnt_q == T_LAST &&
                   obs_q[6:0] == SELECT_OP) begin
         active <= (obs_q[9:7] == rom_id);
      end
   end

   // Output drive. This path is combinational from registers, so an
   // asynchronous reset silences the line in the same cycle.
   always_comb begin
      in_win   = (state_q == LOCKED) && (cnt_q >= T_OUT_FIRST) &&
                 (cnt_q <= T_OUT_LAST);
      bit_off  = cnt_q - T_OUT_FIRST;
      latch_sh = latch_q >> bit_off[3:0];
      is_oe    = in_win & active & ~blank_q & ~resync_err;
      is       = is_oe & latch_sh[0];
   end

   assign locked    = (state_q == LOCKED);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rom_seq.sv
// tb_rom_seq: two rom_seq chips (ROM 0 and ROM 1) share one instruction
// line and one address stream. Each chip has its own copy of the array.
module tb_rom_seq;

   logic       cph2;
   logic       nrst;
   logic       sync;
   logic       ia;
   logic       tb_bus;
   logic       is_bus;
   logic [2:0] rom_id0, rom_id1;
   logic [9:0] rom_data0, rom_data1;
   logic [7:0] rom_addr0, rom_addr1;
   logic       is0, is1, is_oe0, is_oe1;
   logic       active0, active1, locked0, locked1;
   logic       state_dbg0, state_dbg1;

   logic [9:0] mem [256];
   logic [0:0] exp0_q[$];
   logic [0:0] exp1_q[$];
   logic       mon_en;
   logic [0:0] e0, e1;
   int         n_checks;
   int         n_fail;

   assign rom_id0   = 3'd0;
   assign rom_id1   = 3'd1;
   assign rom_data0 = mem[rom_addr0];
   assign rom_data1 = mem[rom_addr1];
   assign is_bus    = tb_bus | is0 | is1;

   rom_seq u0 (
      .cph2(cph2), .nrst(nrst), .sync(sync), .ia(ia), .is_bus(is_bus),
      .rom_id(rom_id0), .rom_data(rom_data0), .rom_addr(rom_addr0),
      .is(is0), .is_oe(is_oe0), .active(active0), .locked(locked0),
      .state_dbg(state_dbg0)
   );

   rom_seq u1 (
      .cph2(cph2), .nrst(nrst), .sync(sync), .ia(ia), .is_bus(is_bus),
      .rom_id(rom_id1), .rom_data(rom_data1), .rom_addr(rom_addr1),
      .is(is1), .is_oe(is_oe1), .active(active1), .locked(locked1),
      .state_dbg(state_dbg1)
   );

   // Clock generation.
   initial cph2 = 1'b0;
   always #5 cph2 = ~cph2;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int which, input logic [9:0] d,
                           input int lo, input int hi);
      for (int b = lo; b <= hi; b++) begin
         if (which == 0) exp0_q.push_back(d[b]);
         else            exp1_q.push_back(d[b]);
      end
   endtask

   // Checks tied to particular bit times of particular words.
   task automatic word_check(input int wid, input int t);
      if (wid == 2 && t == 10) begin
         chk("w2 active0", active0, 1);
         chk("w2 active1", active1, 0);
         chk("w2 locked0", locked0, 1);
         chk("w2 state1", state_dbg1, 1);
      end
      if (wid == 2 && t == 28) chk("w2 addr before load", rom_addr0, 8'h00);
      if (wid == 2 && t == 29) begin
         chk("w2 addr0 loaded", rom_addr0, 8'hA5);
         chk("w2 addr1 shared", rom_addr1, 8'hA5);
      end
      if (wid == 4 && t == 0) begin
         chk("w4 active0 after select", active0, 0);
         chk("w4 active1 after select", active1, 1);
      end
      if (wid == 4 && t == 29) chk("w4 addr1", rom_addr1, 8'h3C);
      if (wid == 5 && t == 50) begin
         chk("w5 locked after resync", locked1, 1);
         chk("w5 state after resync", state_dbg1, 1);
      end
      if (wid == 8 && t == 10) begin
         chk("w8 unlocked0", locked0, 0);
         chk("w8 unlocked1", locked1, 0);
      end
      if (wid == 8 && t == 50) chk("w8 relocked1", locked1, 1);
      if (wid == 10 && t == 50) begin
         chk("w10 reset drops is_oe", is_oe1, 0);
         chk("w10 reset drops is", is1, 0);
      end
      if (wid == 10 && t == 52) begin
         chk("w10 reset active0", active0, 1);
         chk("w10 reset active1", active1, 0);
         chk("w10 reset locked1", locked1, 0);
         chk("w10 reset addr1", rom_addr1, 8'h00);
      end
      if (wid == 11 && t == 30) begin
         chk("w11 still unlocked", locked0, 0);
         chk("w11 no capture", rom_addr0, 8'h00);
      end
      if (wid == 11 && t == 50) chk("w11 locked0", locked0, 1);
   endtask

   // Drives one word; bit time t=0 is where the chips should see T0.
   task automatic do_word(input int wid, input int len, input int s_start,
                          input int s_len, input logic [7:0] addr,
                          input logic [9:0] bus_w, input int rst_a,
                          input int rst_r);
      for (int t = 0; t < len; t++) begin
         @(posedge cph2);
         #1;
         if (t == rst_a) nrst = 1'b0;
         if (t == rst_r) nrst = 1'b1;
         sync   = (t >= s_start) && (t < s_start + s_len);
         ia     = (t >= 20 && t <= 27) ? addr[t-20] : 1'b0;
         tb_bus = (t >= 45 && t <= 54) ? bus_w[t-45] : 1'b0;
         @(negedge cph2);
         word_check(wid, t);
      end
      chk($sformatf("w%0d u0 drained", wid), exp0_q.size(), 0);
      chk($sformatf("w%0d u1 drained", wid), exp1_q.size(), 0);
      exp0_q.delete();
      exp1_q.delete();
   endtask

   // Monitor: pops one expected bit per driven cycle and requires is=0
   // while a chip is idle.
   always @(negedge cph2) begin
      if (mon_en) begin
         if (is_oe0) begin
            if (exp0_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL u0 unexpected drive: got is_oe=1 expected 0 at %0t", $time);
            end else begin
               e0 = exp0_q.pop_front();
               chk("u0 is bit", is0, e0);
            end
         end else begin
            chk("u0 is idle", is0, 0);
         end
         if (is_oe1) begin
            if (exp1_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL u1 unexpected drive: got is_oe=1 expected 0 at %0t", $time);
            end else begin
               e1 = exp1_q.pop_front();
               chk("u1 is bit", is1, e1);
            end
         end else begin
            chk("u1 is idle", is1, 0);
         end
      end
   end

   // Stimulus sequence and final report.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      nrst     = 1'b1;
      sync     = 1'b0;
      ia       = 1'b0;
      tb_bus   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 10'd0;
      mem[8'hA5] = 10'h2B3;
      mem[8'h3C] = 10'h155;

      #3 nrst = 1'b0;
      repeat (3) @(posedge cph2);
      @(negedge cph2);
      chk("reset rom_addr0", rom_addr0, 8'h00);
      chk("reset is_oe0", is_oe0, 0);
      chk("reset is0", is0, 0);
      chk("reset locked0", locked0, 0);
      chk("reset state0", state_dbg0, 0);
      chk("reset active0", active0, 1);
      chk("reset active1", active1, 0);
      @(posedge cph2);
      #1 nrst = 1'b1;
      mon_en = 1'b1;

      // W1: first sync rise locks; ROM 0 drives its zero latch from T46.
      push_exp(0, 10'h000, 1, 9);
      do_word(1, 56, 45, 10, 8'hA5, 10'h000, -1, -1);
      // W2: address 0xA5 fetched and shifted out by ROM 0.
      push_exp(0, 10'h2B3, 0, 9);
      do_word(2, 56, 45, 10, 8'hA5, 10'h000, -1, -1);
      // W3: ROM 0 outputs array[0]=0 while the select-ROM-1 word rides the line.
      push_exp(0, 10'h000, 0, 9);
      do_word(3, 56, 45, 10, 8'h00, 10'b001_0010000, -1, -1);
      // W4: ROM 1 now active.
      push_exp(1, 10'h155, 0, 9);
      do_word(4, 56, 45, 10, 8'h3C, 10'h000, -1, -1);
      // W5: sync arrives 3 cycles early, so nothing is driven this word.
      do_word(5, 53, 42, 10, 8'hA5, 10'h000, -1, -1);
      // W6: clean word after resync.
      push_exp(1, 10'h2B3, 0, 9);
      do_word(6, 56, 45, 10, 8'hA5, 10'h000, -1, -1);
      // W7: normal output, then sync stays high for 12 cycles.
      push_exp(1, 10'h155, 0, 9);
      do_word(7, 57, 45, 12, 8'h3C, 10'h000, -1, -1);
      // W8: relock on the next rise; the old latch is driven from T46.
      push_exp(1, 10'h155, 1, 9);
      do_word(8, 56, 45, 10, 8'hA5, 10'h000, -1, -1);
      // W9: clean word.
      push_exp(1, 10'h2B3, 0, 9);
      do_word(9, 56, 45, 10, 8'hA5, 10'h000, -1, -1);
      // W10: reset lands at T50, after five bits have been driven.
      push_exp(1, 10'h155, 0, 4);
      do_word(10, 56, 45, 10, 8'h3C, 10'h000, 50, -1);
      // W11: release mid-word; ROM 0 locks on the rise and drives from T46.
      push_exp(0, 10'h000, 1, 9);
      do_word(11, 56, 45, 10, 8'hA5, 10'h000, -1, 10);
      // W12: normal operation resumes on ROM 0.
      push_exp(0, 10'h155, 0, 9);
      do_word(12, 56, 45, 10, 8'h3C, 10'h000, -1, -1);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
